// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - op codes, FSM states and op classification helpers for muldiv_unit
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PREP = 2'd1,
        S_CALC = 2'd2,
        S_FIX  = 2'd3
    } state_e;

    function automatic logic is_muldiv(input op_e o);
        return (o == OP_MULT) || (o == OP_MULTU) || (o == OP_DIV) || (o == OP_DIVU);
    endfunction

    function automatic logic is_mul(input op_e o);
        return (o == OP_MULT) || (o == OP_MULTU);
    endfunction

    function automatic logic is_signed_op(input op_e o);
        return (o == OP_MULT) || (o == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_negate.sv
// rtl/muldiv_negate.sv - conditional two's-complement negator
module muldiv_negate #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             neg,
    output logic [WIDTH-1:0] result
);

    assign result = neg ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative shift-add multiplier / restoring divider with HI/LO registers
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_e             state, state_next;
    op_e                op_q;
    op_e                op_in;
    logic [WIDTH-1:0]   a_q, b_q, d_q, hi_q, lo_q;
    logic [2*WIDTH-1:0] p_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               done_q;

    logic               accept, mul_op, sa, sb;
    logic [WIDTH-1:0]   opn_value, opn_result;
    logic               opn_neg;
    logic [2*WIDTH-1:0] resn_value, resn_result;
    logic               resn_neg;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] p_step;

    assign op_in  = op_e'(op);
    assign accept = (state == S_IDLE) && start && !flush;
    assign mul_op = is_mul(op_q);
    assign sa     = is_signed_op(op_q) & a_q[WIDTH-1];
    assign sb     = is_signed_op(op_q) & b_q[WIDTH-1];

    // Both negators serve double duty: operand magnitudes in PREP, sign fix-up in FIX.
    always_comb begin
        if (state == S_FIX) begin
            opn_value  = p_q[2*WIDTH-1:WIDTH];
            opn_neg    = sa;
            resn_value = mul_op ? p_q : {{WIDTH{1'b0}}, p_q[WIDTH-1:0]};
            resn_neg   = sa ^ sb;
        end else begin
            opn_value  = a_q;
            opn_neg    = sa;
            resn_value = {{WIDTH{1'b0}}, b_q};
            resn_neg   = sb;
        end
    end

    muldiv_negate #(.WIDTH(WIDTH)) u_neg_op (
        .value  (opn_value),
        .neg    (opn_neg),
        .result (opn_result)
    );

    muldiv_negate #(.WIDTH(2*WIDTH)) u_neg_res (
        .value  (resn_value),
        .neg    (resn_neg),
        .result (resn_result)
    );

    // One iteration: p_q holds {partial product, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        mul_sum   = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, d_q} : '0);
        div_shift = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, d_q};
        if (mul_op) begin
            p_step = {mul_sum, p_q[WIDTH-1:1]};
        end else if (div_diff[WIDTH]) begin
            p_step = {div_shift[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0};
        end else begin
            p_step = {div_diff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE:  if (accept && is_muldiv(op_in)) state_next = S_PREP;
                S_PREP:  state_next = S_CALC;
                S_CALC:  if (cnt_q == CNT_W'(WIDTH - 1)) state_next = S_FIX;
                S_FIX:   state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state != S_IDLE);
        done = done_q;
        hi   = hi_q;
        lo   = lo_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= OP_MULT;
            a_q    <= '0;
            b_q    <= '0;
            d_q    <= '0;
            p_q    <= '0;
            cnt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q <= op_in;
                        a_q  <= op_a;
                        b_q  <= op_b;
                        if (op_in == OP_MTHI) hi_q <= op_a;
                        if (op_in == OP_MTLO) lo_q <= op_a;
                    end
                end
                S_PREP: begin
                    cnt_q <= '0;
                    if (mul_op) begin
                        p_q <= {{WIDTH{1'b0}}, resn_result[WIDTH-1:0]};
                        d_q <= opn_result;
                    end else begin
                        p_q <= {{WIDTH{1'b0}}, opn_result};
                        d_q <= resn_result[WIDTH-1:0];
                    end
                end
                S_CALC: begin
                    p_q   <= p_step;
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                S_FIX: begin
                    if (!flush) begin
                        done_q <= 1'b1;
                        if (mul_op) begin
                            {hi_q, lo_q} <= resn_result;
                        end else if (b_q == '0) begin
                            hi_q <= a_q;
                            lo_q <= '1;
                        end else begin
                            hi_q <= opn_result;
                            lo_q <= resn_result[WIDTH-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit (vector table + scoreboard)
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .op_a  (op_a),
        .op_b  (op_b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t        vecs[12];
    logic [63:0] sb_q[$];
    logic [63:0] mon_exp;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;
    int          errors = 0;
    int          checks = 0;
    int          done_seen = 0;
    int          lat;
    int          d0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sbv;
        logic [63:0] ua, ub;
        sa  = longint'(signed'(a));
        sbv = longint'(signed'(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        case (o)
            3'd0: return 64'(sa * sbv);
            3'd1: return ua * ub;
            3'd2: if (b == 32'd0) return {a, 32'hFFFFFFFF};
                  else return {32'(sa % sbv), 32'(sa / sbv)};
            3'd3: if (b == 32'd0) return {a, 32'hFFFFFFFF};
                  else return {32'(ua % ub), 32'(ua / ub)};
            default: return 64'd0;
        endcase
    endfunction

    // Called at a negedge; leaves the bench at the negedge after the accepting edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic push, input logic [63:0] exp);
        start = 1'b1;
        op    = o;
        op_a  = a;
        op_b  = b;
        if (push) begin
            sb_q.push_back(exp);
            {exp_hi, exp_lo} = exp;
        end
        if (o == 3'd4) exp_hi = a;
        if (o == 3'd5) exp_lo = a;
        @(negedge clk);
        start = 1'b0;
        op    = 3'($urandom);
        op_a  = $urandom;
        op_b  = $urandom;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            done_seen++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pulse (hi=%h lo=%h)", hi, lo);
            end else begin
                mon_exp = sb_q.pop_front();
                check("result_hilo", {hi, lo}, mon_exp);
            end
        end
    end

    initial begin
        vecs[0]  = '{3'd0, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[1]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[2]  = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{3'd3, 32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF};
        vecs[4]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5]  = '{3'd3, 32'd100,      32'd7,        32'd2,        32'd14};
        vecs[6]  = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
        vecs[7]  = '{3'd0, 32'd7,        32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFDD};
        vecs[8]  = '{3'd1, 32'h00010000, 32'h00010000, 32'd1,        32'd0};
        vecs[9]  = '{3'd2, 32'hFFFFFFFF, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[10] = '{3'd2, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd14};
        vecs[11] = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'd0};

        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_hi", hi, 0);
        check("reset_lo", lo, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, {vecs[i].hi, vecs[i].lo});
            check("busy_after_accept", busy, 1);
            wait_done(lat);
            check("latency", lat, W + 2);
            @(negedge clk);
            check("busy_after_done", busy, 0);
        end

        for (int i = 0; i < 8; i++) begin
            logic [2:0]  ro;
            logic [31:0] ra, rb;
            ro = 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            issue(ro, ra, rb, 1'b1, model(ro, ra, rb));
            wait_done(lat);
            check("rand_latency", lat, W + 2);
            @(negedge clk);
        end

        // MTHI, then a flushed MULT with an ignored start while busy
        issue(3'd4, 32'hA5A5A5A5, 32'd0, 1'b0, 64'd0);
        check("mthi_hi", hi, 32'hA5A5A5A5);
        check("mthi_busy", busy, 0);
        check("mthi_done", done, 0);
        d0 = done_seen;
        issue(3'd0, 32'd5, 32'd6, 1'b0, 64'd0);
        repeat (3) @(negedge clk);
        start = 1'b1; op = 3'd5; op_a = 32'h12345678;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", busy, 0);
        check("flush_hi", hi, exp_hi);
        check("flush_lo_ignored_start", lo, exp_lo);
        repeat (40) @(negedge clk);
        check("flush_no_done", done_seen, d0);

        // flush beats a same-cycle start
        flush = 1'b1; start = 1'b1; op = 3'd4; op_a = 32'h11111111;
        @(negedge clk);
        op = 3'd0;
        @(negedge clk);
        flush = 1'b0; start = 1'b0;
        check("flush_prio_hi", hi, exp_hi);
        check("flush_prio_busy", busy, 0);

        // reserved op is a NOP, MTLO loads lo
        issue(3'd6, 32'hDEADBEEF, 32'd1, 1'b0, 64'd0);
        check("reserved_busy", busy, 0);
        check("reserved_hilo", {hi, lo}, {exp_hi, exp_lo});
        issue(3'd5, 32'h5A5A0000, 32'd0, 1'b0, 64'd0);
        check("mtlo_lo", lo, 32'h5A5A0000);
        check("mtlo_hi", hi, 32'hA5A5A5A5);

        // back-to-back DIVU, second start on the done cycle
        issue(3'd3, 32'd1000, 32'd7, 1'b1, {32'd6, 32'd142});
        wait_done(lat);
        check("b2b_first_latency", lat, W + 2);
        check("b2b_done_cycle_busy", busy, 0);
        issue(3'd3, 32'hFFFFFFFF, 32'd16, 1'b1, {32'hF, 32'h0FFFFFFF});
        check("b2b_second_busy", busy, 1);
        wait_done(lat);
        check("b2b_second_latency", lat, W + 2);
        @(negedge clk);

        // asynchronous reset mid-CALC
        issue(3'd0, 32'd5, 32'd5, 1'b0, 64'd0);
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_done", done, 0);
        check("async_rst_hi", hi, 0);
        check("async_rst_lo", lo, 0);
        exp_hi = '0;
        exp_lo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(3'd1, 32'd3, 32'd4, 1'b1, {32'd0, 32'd12});
        wait_done(lat);
        check("cold_latency", lat, W + 2);
        @(negedge clk);

        check("scoreboard_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
